coef_loader: RTL and testbench

COEF_LOADER -- requirements
Module: coef_loader

---
 rtl/coef_loader.sv | 158 +++++++++++++++
 tb/tb_coef_loader.sv | 325 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/coef_loader.sv
// -----------------------------------------------------------------------------
// coef_loader
//
// Streams a block of filter coefficients from a valid/ready source into a
// single-port coefficient memory with active-low strobes. A load is launched
// by a one-cycle start pulse in IDLE, which captures the first write address
// and the word count. Values above 2**AW are clamped to 2**AW. Write
// addresses wrap modulo 2**AW. One memory write is issued per accepted word,
// so back-to-back transfers sustain one write per cycle.
//
// Optional feature (macro COEF_CHECKSUM_EN): adds output 'checksum', which is
// the running sum modulo 2**DW of the words accepted in the current load. It
// is cleared at start and at reset.
//
// Ports
//   clk       : clock; all state changes on the rising edge
//   rst       : asynchronous active-high reset
//   start     : one-cycle load request; honoured only in IDLE
//   base_addr : first write address, captured at start
//   num_taps  : number of words to load (0..2**AW), captured at start
//   abort     : terminates an active load; no done pulse is issued
//   s_valid   : upstream word valid
//   s_data    : upstream word
//   s_ready   : registered; high exactly while loading
//   mem_D     : memory write data
//   mem_A     : memory write address
//   mem_WEN   : memory write enable, active-low
//   mem_CEN   : memory chip enable, active-low
//   busy      : high while loading
//   done      : one-cycle pulse on completion of a load
//   checksum  : running word sum (only with COEF_CHECKSUM_EN)
// -----------------------------------------------------------------------------
module coef_loader #(
    parameter int DW = 16,
    parameter int AW = 6
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic [AW-1:0] base_addr,
    input  logic [AW:0]   num_taps,
    input  logic          abort,
    input  logic          s_valid,
    input  logic [DW-1:0] s_data,
    output logic          s_ready,
    output logic [DW-1:0] mem_D,
    output logic [AW-1:0] mem_A,
    output logic          mem_WEN,
    output logic          mem_CEN,
    output logic          busy,
    output logic          done
`ifdef COEF_CHECKSUM_EN
    ,
    output logic [DW-1:0] checksum
`endif
);

    localparam logic [AW:0] MAX_TAPS = (AW+1)'(2**AW);
    localparam logic [AW:0] ONE      = (AW+1)'(1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t        state_reg, state_next;
    logic [AW-1:0] base_reg;
    logic [AW:0]   taps_reg;
    logic [AW:0]   index_reg;
    logic [AW:0]   taps_clamped;
    logic          launch;
    logic          xfer;
    logic          last;

    assign taps_clamped = (num_taps > MAX_TAPS) ? MAX_TAPS : num_taps;
    assign launch       = (state_reg == IDLE) && start;
    // A word offered in the abort cycle is dropped, so abort gates the transfer.
    assign xfer         = (state_reg == LOAD) && s_ready && s_valid && !abort;
    assign last         = (index_reg + ONE) == taps_reg;

    // Next-state logic
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE: begin
                if (start) begin
                    state_next = (taps_clamped == '0) ? DONE : LOAD;
                end
            end
            LOAD: begin
                if (abort) begin
                    state_next = IDLE;
                end else if (xfer && last) begin
                    state_next = DONE;
                end
            end
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // State register and registered outputs. s_ready and busy are derived from
    // the next state so that they track the state register exactly.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= IDLE;
            s_ready   <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            mem_WEN   <= 1'b1;
            mem_CEN   <= 1'b1;
            mem_A     <= '0;
            mem_D     <= '0;
            index_reg <= '0;
            base_reg  <= '0;
            taps_reg  <= '0;
        end else begin
            state_reg <= state_next;
            s_ready   <= (state_next == LOAD);
            busy      <= (state_next == LOAD);
            // done trails the DONE state by one cycle, so it appears the
            // cycle after the final write becomes visible.
            done      <= (state_reg == DONE);
            mem_WEN   <= !xfer;
            mem_CEN   <= !xfer;
            if (launch) begin
                base_reg  <= base_addr;
                taps_reg  <= taps_clamped;
                index_reg <= '0;
            end else if (xfer) begin
                index_reg <= index_reg + ONE;
            end
            if (xfer) begin
                mem_D <= s_data;
                // The sum is truncated to AW bits, which gives the address wrap.
                mem_A <= base_reg + index_reg[AW-1:0];
            end
        end
    end

`ifdef COEF_CHECKSUM_EN
    logic [DW-1:0] sum_reg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sum_reg <= '0;
        end else if (launch) begin
            sum_reg <= '0;
        end else if (xfer) begin
            sum_reg <= sum_reg + s_data;
        end
    end

    assign checksum = sum_reg;
`endif

endmodule

// File: tb/tb_coef_loader.sv
module tb_coef_loader;
    localparam int DW = 16;
    localparam int AW = 6;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [AW-1:0] base_addr;
    logic [AW:0]   num_taps;
    logic          abort;
    logic          s_valid;
    logic [DW-1:0] s_data;
    logic          s_ready;
    logic [DW-1:0] mem_D;
    logic [AW-1:0] mem_A;
    logic          mem_WEN;
    logic          mem_CEN;
    logic          busy;
    logic          done;
`ifdef COEF_CHECKSUM_EN
    logic [DW-1:0] checksum;
`endif

    coef_loader #(.DW(DW), .AW(AW)) dut (
        .clk(clk), .rst(rst), .start(start), .base_addr(base_addr),
        .num_taps(num_taps), .abort(abort), .s_valid(s_valid), .s_data(s_data),
        .s_ready(s_ready), .mem_D(mem_D), .mem_A(mem_A), .mem_WEN(mem_WEN),
        .mem_CEN(mem_CEN), .busy(busy), .done(done)
`ifdef COEF_CHECKSUM_EN
        , .checksum(checksum)
`endif
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model: phase 0 = idle, 1 = loading, 2 = load complete.
    int            m_phase;
    int            m_count;
    int            m_taps;
    int            m_base;
    logic [DW-1:0] m_sum;
    logic [AW-1:0] m_a;
    logic [DW-1:0] m_d;
    int            exp_writes;
    int            exp_dones;

    // Observations of the DUT
    logic [AW-1:0] obs_addr[$];
    logic [DW-1:0] obs_data[$];
    int            obs_done;

    task automatic model_reset();
        m_phase = 0; m_count = 0; m_taps = 0; m_base = 0;
        m_sum = '0; m_a = '0; m_d = '0;
    endtask

    task automatic clear_obs();
        obs_addr.delete(); obs_data.delete(); obs_done = 0;
        exp_writes = 0; exp_dones = 0;
    endtask

    // Drives one cycle of inputs (called at posedge+1), predicts the outcome
    // and compares the outputs #1 after the next rising edge.
    task automatic step(input logic st, input logic ab, input logic v, input logic [DW-1:0] d);
        bit            wr;
        bit            dn;
        logic [AW-1:0] ea;
        start = st; abort = ab; s_valid = v; s_data = d;
        wr = (m_phase == 1) && v && !ab;
        dn = (m_phase == 2);
        ea = AW'(m_base + m_count);
        case (m_phase)
            0: if (st) begin
                m_base  = int'(base_addr);
                m_taps  = (int'(num_taps) > 64) ? 64 : int'(num_taps);
                m_count = 0;
                m_sum   = '0;
                m_phase = (m_taps == 0) ? 2 : 1;
            end
            1: if (ab) m_phase = 0;
               else if (wr) begin
                   m_count++;
                   m_sum = m_sum + d;
                   m_a = ea; m_d = d;
                   if (m_count == m_taps) m_phase = 2;
               end
            default: m_phase = 0;
        endcase
        if (wr) exp_writes++;
        if (dn) exp_dones++;
        @(posedge clk); #1;
        start = 1'b0; abort = 1'b0; s_valid = 1'b0;
        checks++;
        if (mem_WEN !== !wr) begin errors++; $display("FAIL cyc_wen: got %b exp %b", mem_WEN, !wr); end
        checks++;
        if (mem_CEN !== !wr) begin errors++; $display("FAIL cyc_cen: got %b exp %b", mem_CEN, !wr); end
        checks++;
        if (mem_A !== m_a) begin errors++; $display("FAIL cyc_addr: got %0d exp %0d", mem_A, m_a); end
        checks++;
        if (mem_D !== m_d) begin errors++; $display("FAIL cyc_data: got %h exp %h", mem_D, m_d); end
        checks++;
        if (s_ready !== (m_phase == 1)) begin errors++; $display("FAIL cyc_ready: got %b exp %b", s_ready, m_phase == 1); end
        checks++;
        if (busy !== (m_phase == 1)) begin errors++; $display("FAIL cyc_busy: got %b exp %b", busy, m_phase == 1); end
        checks++;
        if (done !== dn) begin errors++; $display("FAIL cyc_done: got %b exp %b", done, dn); end
`ifdef COEF_CHECKSUM_EN
        checks++;
        if (checksum !== m_sum) begin errors++; $display("FAIL cyc_checksum: got %h exp %h", checksum, m_sum); end
`endif
        if (mem_WEN === 1'b0) begin obs_addr.push_back(mem_A); obs_data.push_back(mem_D); end
        if (done === 1'b1) obs_done++;
        $display("cycle: st=%b ab=%b v=%b d=%h -> WEN=%b A=%0d D=%h rdy=%b done=%b",
                 st, ab, v, d, mem_WEN, mem_A, mem_D, s_ready, done);
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 0; abort = 0; s_valid = 0; s_data = '0;
        base_addr = '0; num_taps = '0;
        model_reset(); clear_obs();
        #2;
        checks++;
        if ({mem_WEN, mem_CEN, s_ready, busy, done} !== 5'b11000) begin
            errors++; $display("FAIL reset_ctrl: got %b exp 11000", {mem_WEN, mem_CEN, s_ready, busy, done});
        end
        checks++;
        if (mem_A !== '0 || mem_D !== '0) begin
            errors++; $display("FAIL reset_mem: got A=%0d D=%h exp 0/0", mem_A, mem_D);
        end
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        step(0, 0, 0, '0);
    endtask

    task automatic test_basic();
        logic [DW-1:0] d[4];
        d[0] = 16'h0011; d[1] = 16'h0022; d[2] = 16'h0033; d[3] = 16'h0044;
        clear_obs();
        base_addr = 6'd0; num_taps = 7'd4;
        step(1, 0, 0, '0);
        for (int i = 0; i < 4; i++) step(0, 0, 1, d[i]);
        repeat (2) step(0, 0, 0, '0);
        checks++;
        if (obs_addr.size() != 4) begin errors++; $display("FAIL basic_count: got %0d exp 4", obs_addr.size()); end
        for (int i = 0; i < 4 && i < obs_addr.size(); i++) begin
            checks++;
            if (obs_addr[i] !== AW'(i) || obs_data[i] !== d[i]) begin
                errors++; $display("FAIL basic_write%0d: got %0d/%h exp %0d/%h", i, obs_addr[i], obs_data[i], i, d[i]);
            end
        end
        checks++;
        if (obs_done != 1) begin errors++; $display("FAIL basic_done: got %0d exp 1", obs_done); end
`ifdef COEF_CHECKSUM_EN
        checks++;
        if (checksum !== 16'h00AA) begin errors++; $display("FAIL basic_checksum: got %h exp 00aa", checksum); end
`endif
    endtask

    task automatic test_wrap();
        clear_obs();
        base_addr = 6'd62; num_taps = 7'd4;
        step(1, 0, 0, '0);
        for (int i = 0; i < 4; i++) step(0, 0, 1, DW'($urandom));
        repeat (2) step(0, 0, 0, '0);
        checks++;
        if (obs_addr.size() != 4) begin errors++; $display("FAIL wrap_count: got %0d exp 4", obs_addr.size()); end
        for (int i = 0; i < 4 && i < obs_addr.size(); i++) begin
            checks++;
            if (obs_addr[i] !== AW'((62 + i) % 64)) begin
                errors++; $display("FAIL wrap_addr%0d: got %0d exp %0d", i, obs_addr[i], (62 + i) % 64);
            end
        end
    endtask

    task automatic test_gaps();
        bit pat[5];
        pat[0] = 1; pat[1] = 0; pat[2] = 1; pat[3] = 0; pat[4] = 1;
        clear_obs();
        base_addr = 6'd10; num_taps = 7'd3;
        step(1, 0, 0, '0);
        for (int i = 0; i < 5; i++) step(0, 0, pat[i], DW'($urandom));
        repeat (3) step(0, 0, 1, DW'($urandom));
        checks++;
        if (obs_addr.size() != 3 || obs_done != 1) begin
            errors++; $display("FAIL gaps: got %0d writes %0d dones exp 3 writes 1 done", obs_addr.size(), obs_done);
        end
    endtask

    task automatic test_zero_and_clamp();
        clear_obs();
        base_addr = 6'd5; num_taps = 7'd0;
        step(1, 0, 0, '0);
        step(0, 0, 1, 16'h1234);
        checks++;
        if (done !== 1'b1) begin errors++; $display("FAIL zero_done_timing: got %b exp 1", done); end
        step(0, 0, 1, 16'h1234);
        checks++;
        if (obs_addr.size() != 0 || obs_done != 1) begin
            errors++; $display("FAIL zero: got %0d writes %0d dones exp 0 writes 1 done", obs_addr.size(), obs_done);
        end
        clear_obs();
        base_addr = 6'd7; num_taps = 7'd100;
        step(1, 0, 0, '0);
        for (int i = 0; i < 70; i++) step(0, 0, 1, DW'($urandom));
        checks++;
        if (obs_addr.size() != 64 || obs_done != 1) begin
            errors++; $display("FAIL clamp: got %0d writes %0d dones exp 64 writes 1 done", obs_addr.size(), obs_done);
        end
    endtask

    task automatic test_abort();
        clear_obs();
        base_addr = 6'd20; num_taps = 7'd8;
        step(1, 0, 0, '0);
        step(0, 0, 1, 16'hA001);
        step(0, 0, 1, 16'hA002);
        step(0, 1, 1, 16'hA003);   // offered word is dropped
        step(1, 1, 1, 16'hBEEF);   // abort with start in IDLE: start wins
        checks++;
        if (obs_addr.size() != 2 || obs_done != 0) begin
            errors++; $display("FAIL abort: got %0d writes %0d dones exp 2 writes 0 done", obs_addr.size(), obs_done);
        end
        clear_obs();
        for (int i = 0; i < 8; i++) step(0, 0, 1, DW'($urandom));
        repeat (2) step(0, 0, 0, '0);
        checks++;
        if (obs_addr.size() != 8 || obs_done != 1 || obs_addr[0] !== 6'd20) begin
            errors++; $display("FAIL abort_reload: got %0d writes %0d dones exp 8 writes 1 done from 20", obs_addr.size(), obs_done);
        end
    endtask

    task automatic test_start_ignored();
        clear_obs();
        base_addr = 6'd40; num_taps = 7'd5;
        step(1, 0, 0, '0);
        step(0, 0, 1, DW'($urandom));
        base_addr = 6'd3; num_taps = 7'd2;
        for (int i = 0; i < 5; i++) step(i == 1, 0, 1, DW'($urandom));
        checks++;
        if (obs_addr.size() != 5 || obs_addr[4] !== 6'd44) begin
            errors++; $display("FAIL start_ignored: got %0d writes exp 5 ending at 44", obs_addr.size());
        end
    endtask

    task automatic test_reset_mid();
        clear_obs();
        base_addr = 6'd1; num_taps = 7'd8;
        step(1, 0, 0, '0);
        for (int i = 0; i < 3; i++) step(0, 0, 1, DW'($urandom));
        #2 rst = 1'b1;
        #1;
        checks++;
        if ({mem_WEN, mem_CEN, s_ready, busy} !== 4'b1100) begin
            errors++; $display("FAIL reset_mid_async: got %b exp 1100", {mem_WEN, mem_CEN, s_ready, busy});
        end
        model_reset();
        for (int i = 0; i < 3; i++) begin
            s_valid = 1'b1;
            @(posedge clk); #1;
            checks++;
            if (done !== 1'b0 || mem_WEN !== 1'b1) begin
                errors++; $display("FAIL reset_mid_hold: got done=%b WEN=%b exp 0/1", done, mem_WEN);
            end
        end
        rst = 1'b0; s_valid = 1'b0;
        repeat (3) step(0, 0, 1, DW'($urandom));
    endtask

    task automatic test_random();
        for (int k = 0; k < 6; k++) begin
            int cyc;
            bit aborted;
            int want;
            clear_obs();
            aborted = 0;
            base_addr = AW'($urandom);
            num_taps = 7'($urandom_range(0, 90));
            want = (int'(num_taps) > 64) ? 64 : int'(num_taps);
            step(1, 0, 0, '0);
            cyc = 0;
            while (m_phase != 0 && cyc < 400) begin
                bit ab;
                ab = ($urandom_range(0, 49) == 0);
                if (ab && m_phase == 1) aborted = 1;
                step(0, ab, 1'($urandom), DW'($urandom));
                cyc++;
            end
            checks++;
            if (m_phase != 0) begin errors++; $display("FAIL random_timeout: load %0d did not finish", k); end
            checks++;
            if (obs_addr.size() != exp_writes || obs_done != exp_dones) begin
                errors++; $display("FAIL random_totals: got %0d writes %0d dones exp %0d/%0d", obs_addr.size(), obs_done, exp_writes, exp_dones);
            end
            if (!aborted) begin
                checks++;
                if (obs_addr.size() != want) begin
                    errors++; $display("FAIL random_len: got %0d writes exp %0d", obs_addr.size(), want);
                end
            end
            for (int i = 0; i < obs_addr.size(); i++) begin
                checks++;
                if (obs_addr[i] !== AW'(int'(base_addr) + i)) begin
                    errors++; $display("FAIL random_addr: got %0d exp %0d", obs_addr[i], AW'(int'(base_addr) + i));
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_wrap();
        test_gaps();
        test_zero_and_clamp();
        test_abort();
        test_start_ignored();
        test_reset_mid();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
